cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
Round-robin arbiter for the Common Data Bus (CDB) in the Tomasulo datapath. Functional units / reservation stations (ADD1, ADD2, …) finish execution and request the single CDB to broadcast a result tagged with their station ID. The arbiter grants one requester per cycle and drives a registered CDB broadcast (valid, tag, data). The register status table and the reservation stations snoop that broadcast to resolve Qi/Qj/Qk.

Parameters:
N_REQ, 4, number of requesters (2..8); requester i carries station tag i+1
TAG_W, 3, width of station tag; tag 0 = "no station" (free register), never broadcast
DATA_W, 16, result data width

Ports:
Clock  in  1  system clock, all state on rising edge
Reset  in  1  synchronous, active-high reset
Req  in  N_REQ  per-requester request, level, held until granted
Req_Tag  in  N_REQ*TAG_W  tags, requester i at bits [i*TAG_W +: TAG_W]
Req_Data  in  N_REQ*DATA_W  results, requester i at bits [i*DATA_W +: DATA_W]
Cdb_Hold  in  1  when 1, no new grant this cycle (CDB consumer stalled)
Grant  out  N_REQ  one-hot grant, registered, high for exactly one cycle
Cdb_Valid  out  1  broadcast valid, registered
Cdb_Tag  out  TAG_W  broadcast station tag, registered
Cdb_Data  out  DATA_W  broadcast result, registered
Tag_Error  out  1  sticky: a request carried tag 0
Busy_Cycles  out  8  saturating count of cycles where ≥1 eligible request was not granted

Behaviour:
- Reset (sync, Reset=1 at rising edge): Grant=0, Cdb_Valid=0, Cdb_Tag=0, Cdb_Data=16'hFFF0 (the datapath's "no value" pattern), Tag_Error=0, Busy_Cycles=0, RR pointer Last=N_REQ-1 (requester 0 has top priority first). Reset wins over every other input in the same cycle; a grant in flight is dropped, not re-issued.
- Eligibility per edge: Elig[i] = Req[i] & ~Grant[i] & (tag_i != 0). Masking by the current Grant lets a requester drop Req the cycle after seeing its grant without a double grant. Consequence: minimum spacing between two grants to the same requester = 2 cycles.
- Selection: if Cdb_Hold=0 and Elig≠0, pick the first eligible index searching Last+1, Last+2, … modulo N_REQ. At that edge: Grant=onehot(sel), Cdb_Valid=1, Cdb_Tag=tag_sel, Cdb_Data=data_sel, Last=sel.
- No selection (Hold=1 or Elig=0): Grant=0, Cdb_Valid=0, Cdb_Tag=0, Cdb_Data=16'hFFF0, Last unchanged.
- Latency: Req sampled at edge k → Grant and CDB valid during cycle after edge k (1 cycle). Broadcast lasts exactly one cycle.
- Handshake: requester keeps Req/Tag/Data stable until it samples Grant[i]=1, and deasserts Req no later than the following edge. Tag/Data changing while Req=1 and not granted is a protocol violation (undefined result).
- Tag 0: a request with tag 0 is never granted; Tag_Error is set at that edge and holds until Reset.
- Busy_Cycles increments by 1 at each edge where (popcount(Elig) > number granted), i.e. Hold with Elig≠0, or ≥2 eligible. Saturates at 255 (no wrap).
- Fairness: with all N_REQ requesting continuously (re-asserting after 1 idle cycle), each requester is granted at least once in any N_REQ+1 consecutive cycles.
- Cdb_Hold asserted mid-stream: current registered broadcast still completes its one cycle; the next grant is deferred; pointer frozen.

Test Plan:
- Reset then idle: Reset=1 for 2 cycles, Req=0 → Grant=0, Cdb_Valid=0, Cdb_Data=16'hFFF0, Tag_Error=0, Busy_Cycles=0.
- Single request: Req=4'b0010, tag1=3'd2, data1=16'h00A5 → next cycle Grant=4'b0010, Cdb_Valid=1, Cdb_Tag=2, Cdb_Data=16'h00A5; requester drops Req → following cycle Cdb_Valid=0; no second grant even if Req held one extra cycle.
- Round-robin: Req=4'b1111 held (each drops 1 cycle after grant, then re-asserts), tags 1..4 → grant order 0,1,2,3,0…; no requester waits more than N_REQ+1 cycles; Busy_Cycles increments each contended cycle.
- Hold: Req=4'b0101, Cdb_Hold=1 for 3 cycles → Grant=0, Cdb_Valid=0, Busy_Cycles=3; Hold released → Grant=4'b0001 then 4'b0100 two cycles later.
- Tag 0 request: Req=4'b1000, tag3=0 → never granted, Tag_Error=1 next cycle and sticky until Reset; other requesters are still served normally.
- Reset mid-operation: Reset asserted in the cycle Grant=4'b0100 is high → next cycle all outputs at reset values and Last=N_REQ-1; with Req=4'b0101 after reset, requester 0 is granted first.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_if
//
// Bundle for the Common Data Bus arbiter. It carries the requester side
// (requests, station tags, results, consumer stall) and the registered
// broadcast side (grant, valid, tag, data, status).
//
// Signals:
//   Req          requester -> arbiter  per-requester level request
//   Req_Tag      requester -> arbiter  station tags, requester i at [i*TAG_W +: TAG_W]
//   Req_Data     requester -> arbiter  results, requester i at [i*DATA_W +: DATA_W]
//   Cdb_Hold     consumer  -> arbiter  suppress any new grant this cycle
//   Grant        arbiter   -> requester one-hot grant, high for one cycle
//   Cdb_Valid    arbiter   -> snoopers  broadcast valid
//   Cdb_Tag      arbiter   -> snoopers  broadcast station tag
//   Cdb_Data     arbiter   -> snoopers  broadcast result
//   Tag_Error    arbiter   -> status    sticky: a request carried tag 0
//   Busy_Cycles  arbiter   -> status    saturating count of contended cycles
//
// Modports:
//   master  the requester / consumer side (drives requests and hold)
//   slave   the arbiter itself
// -----------------------------------------------------------------------------
interface cdb_arbiter_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned TAG_W  = 3,
    parameter int unsigned DATA_W = 16
);

    logic [N_REQ-1:0]        Req;
    logic [N_REQ*TAG_W-1:0]  Req_Tag;
    logic [N_REQ*DATA_W-1:0] Req_Data;
    logic                    Cdb_Hold;

    logic [N_REQ-1:0]        Grant;
    logic                    Cdb_Valid;
    logic [TAG_W-1:0]        Cdb_Tag;
    logic [DATA_W-1:0]       Cdb_Data;
    logic                    Tag_Error;
    logic [7:0]              Busy_Cycles;

    modport master (
        output Req,
        output Req_Tag,
        output Req_Data,
        output Cdb_Hold,
        input  Grant,
        input  Cdb_Valid,
        input  Cdb_Tag,
        input  Cdb_Data,
        input  Tag_Error,
        input  Busy_Cycles
    );

    modport slave (
        input  Req,
        input  Req_Tag,
        input  Req_Data,
        input  Cdb_Hold,
        output Grant,
        output Cdb_Valid,
        output Cdb_Tag,
        output Cdb_Data,
        output Tag_Error,
        output Busy_Cycles
    );

endinterface

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Round-robin arbiter for the single Common Data Bus of the Tomasulo datapath.
// Reservation stations that finished execution raise Req with their station
// tag and result; one of them is granted per cycle and its tag/result are
// broadcast on the registered CDB for exactly one cycle, where the register
// status table and the reservation stations snoop it.
//
// Parameters:
//   N_REQ   number of requesters (2..8); requester i carries station tag i+1
//   TAG_W   station tag width; tag 0 means "no station" and is never broadcast
//   DATA_W  result width
//
// Ports:
//   Clock   rising-edge clock for all state
//   Reset   synchronous, active-high; wins over every other input
//   bus     cdb_arbiter_if slave modport:
//             Req/Req_Tag/Req_Data/Cdb_Hold in,
//             Grant/Cdb_Valid/Cdb_Tag/Cdb_Data/Tag_Error/Busy_Cycles out
//
// Timing: requests sampled at edge k produce Grant and the broadcast during
// the cycle after edge k. All outputs come straight from flops.
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned TAG_W  = 3,
    parameter int unsigned DATA_W = 16
) (
    input  logic         Clock,
    input  logic         Reset,
    cdb_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    // Datapath-wide "no value" pattern driven while the CDB is idle.
    localparam logic [DATA_W-1:0] NO_VALUE = DATA_W'(16'hFFF0);

    // Pointer starts at the last requester so requester 0 wins first.
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

    localparam logic [7:0] BUSY_MAX = 8'hFF;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [N_REQ-1:0]  grant_q,     grant_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q,   cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q,  cdb_data_d;
    logic              tag_error_q, tag_error_d;
    logic [7:0]        busy_q,      busy_d;
    logic [IDX_W-1:0]  last_q,      last_d;

    // -------------------------------------------------------------------------
    // Combinational decision signals
    // -------------------------------------------------------------------------
    logic [N_REQ-1:0]  elig;
    logic [N_REQ-1:0]  tag_zero;
    logic              sel_found;
    logic [IDX_W-1:0]  sel_idx;
    int unsigned       cand;
    logic              do_grant;
    int unsigned       elig_cnt;
    logic              busy_inc;

    // -------------------------------------------------------------------------
    // Eligibility
    // A requester currently holding Grant is masked so it can keep Req high
    // for the edge after its grant without being served twice. Tag 0 is not
    // a real station and is never eligible, only flagged.
    // -------------------------------------------------------------------------
    always_comb begin
        elig     = '0;
        tag_zero = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (bus.Req_Tag[i*TAG_W +: TAG_W] == '0) begin
                tag_zero[i] = bus.Req[i];
            end else begin
                elig[i] = bus.Req[i] & ~grant_q[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Round-robin pick: first eligible index at Last+1, Last+2, ... mod N_REQ.
    // The final offset (N_REQ) wraps back to Last itself, so the most recent
    // winner is considered only when nobody else is eligible.
    // -------------------------------------------------------------------------
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = last_q;
        cand      = 0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            cand = (32'(last_q) + off) % N_REQ;
            if (!sel_found && elig[cand[IDX_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // A stalled consumer blocks the new grant but not the broadcast already
    // sitting in the output registers.
    assign do_grant = sel_found & ~bus.Cdb_Hold;

    // Contended cycle: more eligible requesters than grants issued.
    always_comb begin
        elig_cnt = $countones(elig);
        busy_inc = (elig_cnt > (do_grant ? 32'd1 : 32'd0));
    end

    // -------------------------------------------------------------------------
    // Next-state
    // -------------------------------------------------------------------------
    always_comb begin
        grant_d     = '0;
        cdb_valid_d = 1'b0;
        cdb_tag_d   = '0;
        cdb_data_d  = NO_VALUE;
        last_d      = last_q;

        if (do_grant) begin
            grant_d[sel_idx] = 1'b1;
            cdb_valid_d      = 1'b1;
            cdb_tag_d        = bus.Req_Tag[sel_idx*TAG_W +: TAG_W];
            cdb_data_d       = bus.Req_Data[sel_idx*DATA_W +: DATA_W];
            last_d           = sel_idx;
        end

        tag_error_d = tag_error_q | (|tag_zero);

        busy_d = busy_q;
        if (busy_inc && (busy_q != BUSY_MAX)) begin
            busy_d = busy_q + 8'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Registers (synchronous reset; a grant decided in the reset cycle is lost)
    // -------------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            grant_q     <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= NO_VALUE;
            tag_error_q <= 1'b0;
            busy_q      <= '0;
            last_q      <= LAST_RST;
        end else begin
            grant_q     <= grant_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            tag_error_q <= tag_error_d;
            busy_q      <= busy_d;
            last_q      <= last_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.Grant       = grant_q;
    assign bus.Cdb_Valid   = cdb_valid_q;
    assign bus.Cdb_Tag     = cdb_tag_q;
    assign bus.Cdb_Data    = cdb_data_q;
    assign bus.Tag_Error   = tag_error_q;
    assign bus.Busy_Cycles = busy_q;

    // -------------------------------------------------------------------------
    // Invariants of the registered broadcast
    // -------------------------------------------------------------------------
    a_grant_onehot : assert property (@(posedge Clock) disable iff (Reset)
        $onehot0(grant_q));

    a_valid_matches_grant : assert property (@(posedge Clock) disable iff (Reset)
        cdb_valid_q == (grant_q != '0));

    a_no_tag0_broadcast : assert property (@(posedge Clock) disable iff (Reset)
        cdb_valid_q |-> (cdb_tag_q != '0));

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Bench for cdb_arbiter. A reference model, evaluated on the inputs just
// before each rising edge, pushes the expected registered outputs into a
// scoreboard queue; after the edge the entry is popped and compared with the
// DUT outputs. Directed constant checks cover the specific scenarios.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned TAG_W  = 3;
    localparam int unsigned DATA_W = 16;
    localparam logic [DATA_W-1:0] NO_VALUE = 16'hFFF0;

    typedef struct packed {
        logic [N_REQ-1:0]  grant;
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic              tag_err;
        logic [7:0]        busy;
    } exp_t;

    logic Clock = 1'b0;
    logic Reset;

    always #5 Clock = ~Clock;

    cdb_arbiter_if #(.N_REQ(N_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

    cdb_arbiter #(.N_REQ(N_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    exp_t sb_q[$];

    // Reference model state
    int               m_last;
    logic [N_REQ-1:0] m_grant;
    logic             m_tag_err;
    int               m_busy;

    // Stimulus bookkeeping
    int phase     [N_REQ];
    int active    [N_REQ];
    int linger    [N_REQ];
    int age       [N_REQ];
    int last_seen [N_REQ];
    int max_gap;
    int gidx;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        bus.Req[i] = 1'b1;
        bus.Req_Tag[i*TAG_W +: TAG_W] = t;
        bus.Req_Data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic clear_req(input int i);
        bus.Req[i] = 1'b0;
    endtask

    // Model: expected outputs after the coming edge, from current inputs.
    task automatic model_push();
        exp_t             e;
        logic [N_REQ-1:0] el;
        int               n_elig;
        int               pick;
        int               c;
        logic             tz;
        logic [TAG_W-1:0] tj;
        if (Reset) begin
            m_last    = N_REQ - 1;
            m_grant   = '0;
            m_tag_err = 1'b0;
            m_busy    = 0;
            e.grant   = '0;
            e.valid   = 1'b0;
            e.tag     = '0;
            e.data    = NO_VALUE;
        end else begin
            el     = '0;
            n_elig = 0;
            tz     = 1'b0;
            for (int j = 0; j < N_REQ; j++) begin
                tj = bus.Req_Tag[j*TAG_W +: TAG_W];
                if (bus.Req[j] && tj == 0) tz = 1'b1;
                if (bus.Req[j] && !m_grant[j] && tj != 0) begin
                    el[j] = 1'b1;
                    n_elig++;
                end
            end
            pick = -1;
            if (!bus.Cdb_Hold) begin
                c = m_last;
                for (int k = 0; k < N_REQ; k++) begin
                    c = (c + 1) % N_REQ;
                    if (pick < 0 && el[c]) pick = c;
                end
            end
            if (n_elig > ((pick >= 0) ? 1 : 0) && m_busy < 255) m_busy++;
            if (tz) m_tag_err = 1'b1;
            if (pick >= 0) begin
                e.grant = '0;
                e.grant[pick] = 1'b1;
                e.valid = 1'b1;
                e.tag   = bus.Req_Tag[pick*TAG_W +: TAG_W];
                e.data  = bus.Req_Data[pick*DATA_W +: DATA_W];
                m_last  = pick;
            end else begin
                e.grant = '0;
                e.valid = 1'b0;
                e.tag   = '0;
                e.data  = NO_VALUE;
            end
            m_grant = e.grant;
        end
        e.tag_err = m_tag_err;
        e.busy    = m_busy[7:0];
        sb_q.push_back(e);
    endtask

    // One clock: predict, clock, compare outputs #1 after the edge.
    task automatic step();
        exp_t e;
        model_push();
        @(posedge Clock);
        #1;
        e = sb_q.pop_front();
        check("grant",     32'(bus.Grant),       32'(e.grant));
        check("cdb_valid", 32'(bus.Cdb_Valid),   32'(e.valid));
        check("cdb_tag",   32'(bus.Cdb_Tag),     32'(e.tag));
        check("cdb_data",  32'(bus.Cdb_Data),    32'(e.data));
        check("tag_error", 32'(bus.Tag_Error),   32'(e.tag_err));
        check("busy",      32'(bus.Busy_Cycles), 32'(e.busy));
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
    endtask

    initial begin
        Reset        = 1'b1;
        bus.Req      = '0;
        bus.Req_Tag  = '0;
        bus.Req_Data = '0;
        bus.Cdb_Hold = 1'b0;

        // Reset then idle
        step();
        step();
        check("rst_grant", 32'(bus.Grant),       32'h0);
        check("rst_valid", 32'(bus.Cdb_Valid),   32'h0);
        check("rst_data",  32'(bus.Cdb_Data),    32'hFFF0);
        check("rst_tagerr", 32'(bus.Tag_Error),  32'h0);
        check("rst_busy",  32'(bus.Busy_Cycles), 32'h0);
        Reset = 1'b0;

        // Single request, held one extra edge after grant
        set_req(1, 3'd2, 16'h00A5);
        step();
        check("single_grant", 32'(bus.Grant),     32'h2);
        check("single_valid", 32'(bus.Cdb_Valid), 32'h1);
        check("single_tag",   32'(bus.Cdb_Tag),   32'h2);
        check("single_data",  32'(bus.Cdb_Data),  32'h00A5);
        step();
        check("single_no_regrant", 32'(bus.Grant),     32'h0);
        check("single_valid_drop", 32'(bus.Cdb_Valid), 32'h0);
        clear_req(1);
        step();
        check("single_idle", 32'(bus.Cdb_Valid), 32'h0);

        // Round robin: all request, each drops one edge after grant then re-asserts
        do_reset();
        for (int i = 0; i < N_REQ; i++) begin
            set_req(i, 3'(i + 1), 16'(16'h1000 + i));
            phase[i]     = 0;
            last_seen[i] = -1;
        end
        max_gap = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            step();
            gidx = -1;
            for (int j = 0; j < N_REQ; j++) if (bus.Grant[j]) gidx = j;
            check("rr_order", 32'(gidx), 32'(cyc % N_REQ));
            if (gidx >= 0) begin
                if (cyc - last_seen[gidx] > max_gap) max_gap = cyc - last_seen[gidx];
                last_seen[gidx] = cyc;
            end
            for (int i = 0; i < N_REQ; i++) begin
                case (phase[i])
                    0: if (m_grant[i]) phase[i] = 1;
                    1: begin clear_req(i); phase[i] = 2; end
                    default: begin set_req(i, 3'(i + 1), 16'(16'h1000 + i)); phase[i] = 0; end
                endcase
            end
        end
        check("rr_fair_gap", 32'(max_gap <= N_REQ + 1), 32'h1);
        check("rr_busy", 32'(bus.Busy_Cycles), 32'd20);
        bus.Req = '0;
        step();

        // Hold with two requesters pending
        do_reset();
        set_req(0, 3'd1, 16'h0111);
        set_req(2, 3'd3, 16'h0333);
        bus.Cdb_Hold = 1'b1;
        step();
        step();
        step();
        check("hold_grant", 32'(bus.Grant), 32'h0);
        check("hold_busy",  32'(bus.Busy_Cycles), 32'd3);
        bus.Cdb_Hold = 1'b0;
        step();
        check("hold_rel_grant0", 32'(bus.Grant),    32'h1);
        check("hold_rel_data0",  32'(bus.Cdb_Data), 32'h0111);
        step();
        check("hold_rel_grant2", 32'(bus.Grant),    32'h4);
        check("hold_rel_data2",  32'(bus.Cdb_Data), 32'h0333);
        clear_req(0);
        step();
        clear_req(2);
        step();

        // Tag 0 request: never granted, sticky error, others served
        do_reset();
        set_req(3, 3'd0, 16'hDEAD);
        set_req(1, 3'd2, 16'h0222);
        step();
        check("tag0_other_grant", 32'(bus.Grant),     32'h2);
        check("tag0_error",       32'(bus.Tag_Error), 32'h1);
        step();
        clear_req(1);
        step();
        step();
        check("tag0_never_granted", 32'(bus.Grant), 32'h0);
        clear_req(3);
        step();
        check("tag0_sticky", 32'(bus.Tag_Error), 32'h1);
        do_reset();
        check("tag0_cleared", 32'(bus.Tag_Error), 32'h0);

        // Reset while Grant=0100 is high
        set_req(0, 3'd1, 16'h0AAA);
        set_req(2, 3'd3, 16'h0CCC);
        step();
        check("rmid_first", 32'(bus.Grant), 32'h1);
        step();
        check("rmid_second", 32'(bus.Grant), 32'h4);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("rmid_rst_grant", 32'(bus.Grant),    32'h0);
        check("rmid_rst_data",  32'(bus.Cdb_Data), 32'hFFF0);
        step();
        check("rmid_after_grant", 32'(bus.Grant), 32'h1);
        bus.Req = '0;
        step();

        // Pointer restart: last winner is requester 1, reset, then 1 and 2 request
        set_req(1, 3'd2, 16'h0B0B);
        step();
        check("ptr_pre_grant", 32'(bus.Grant), 32'h2);
        bus.Req = '0;
        step();
        do_reset();
        set_req(1, 3'd2, 16'h0B0B);
        set_req(2, 3'd3, 16'h0C0C);
        step();
        check("ptr_after_reset", 32'(bus.Grant), 32'h2);
        bus.Req = '0;
        step();
        step();

        // Randomized protocol-abiding traffic with hold and occasional reset
        for (int i = 0; i < N_REQ; i++) begin
            active[i] = 0;
            linger[i] = 0;
            age[i]    = 0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            Reset        = ($urandom_range(63) == 0);
            bus.Cdb_Hold = ($urandom_range(3) == 0);
            for (int i = 0; i < N_REQ; i++) begin
                if (active[i] == 0 && $urandom_range(2) == 0) begin
                    set_req(i, ($urandom_range(15) == 0) ? 3'd0 : 3'(i + 1), 16'($urandom));
                    active[i] = 1;
                    age[i]    = 0;
                end
            end
            step();
            for (int i = 0; i < N_REQ; i++) begin
                if (active[i] != 0) begin
                    if (linger[i] != 0) begin
                        clear_req(i);
                        active[i] = 0;
                        linger[i] = 0;
                    end else if (m_grant[i]) begin
                        if ($urandom_range(1) == 0) begin
                            clear_req(i);
                            active[i] = 0;
                        end else begin
                            linger[i] = 1;
                        end
                    end else if (bus.Req_Tag[i*TAG_W +: TAG_W] == 0) begin
                        age[i]++;
                        if (age[i] >= 3) begin
                            clear_req(i);
                            active[i] = 0;
                        end
                    end
                end
            end
        end
        Reset        = 1'b0;
        bus.Cdb_Hold = 1'b0;
        bus.Req      = '0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
